// File: rtl/fir_pkg.sv
// Shared types, sizes and number-format helpers for the time-multiplexed FIR band scheduler.
package fir_pkg;

    localparam int ORDER  = 30;
    localparam int BANDS  = 4;
    localparam int TAP_W  = 5;
    localparam int BAND_W = 2;
    localparam int ACC_W  = 36;

    localparam logic [15:0] SAT_MAG = 16'h7FFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // 31-bit sign-magnitude product {sign, 30-bit magnitude} to accumulator two's complement.
    function automatic logic signed [ACC_W-1:0] sm_to_tc(input logic [30:0] sm);
        logic signed [ACC_W-1:0] mag;
        mag = signed'({6'd0, sm[29:0]});
        return sm[30] ? -mag : mag;
    endfunction

    // Accumulator to 16-bit sign-magnitude; bit 16 of the result flags saturation.
    function automatic logic [16:0] tc_to_sm(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-1:0] mag;
        logic             neg;
        neg = v[ACC_W-1];
        mag = neg ? unsigned'(-v) : unsigned'(v);
        if (mag >= 36'h0_4000_0000) begin
            return {1'b1, neg, SAT_MAG[14:0]};
        end
        if (mag[29:15] == 15'd0) begin
            return 17'd0;
        end
        return {1'b0, neg, mag[29:15]};
    endfunction

endpackage

// File: rtl/fir_sm_mult.sv
// Combinational 16x16 sign-magnitude multiply; a zero magnitude always comes out positive.
module fir_sm_mult (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [30:0] p_o
);

    logic [29:0] mag;

    assign mag = {15'd0, a_i[14:0]} * {15'd0, b_i[14:0]};
    assign p_o = {(a_i[15] ^ b_i[15]) & (mag != 30'd0), mag};

endmodule

// File: rtl/fir_band_scheduler.sv
// Sequences one shared sign-magnitude MAC over every enabled band's taps for each accepted sample.
module fir_band_scheduler
    import fir_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             fir_in,
    input  logic [BANDS-1:0]        band_en,
    output logic [BAND_W+TAP_W-1:0] coef_addr,
    output logic                    coef_rd,
    input  logic [15:0]             coef_data,
    output logic                    out_valid,
    output logic [BAND_W-1:0]       out_band,
    output logic [15:0]             fir_out,
    output logic                    busy,
    output logic                    overflow
);

    localparam logic [TAP_W:0]   M_LAST   = (TAP_W+1)'(ORDER);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(ORDER - 1);

    state_e                  state_q, state_d;
    logic [TAP_W:0]          m_q;
    logic [BAND_W-1:0]       band_q;
    logic [BANDS-1:0]        mask_q;
    logic [TAP_W-1:0]        wr_ptr_q;
    logic [TAP_W-1:0]        samp_ptr_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [15:0]             hist_q [ORDER];
    logic [15:0]             fir_out_q;
    logic                    out_valid_q;
    logic [BAND_W-1:0]       out_band_q;
    logic                    ovf_q;

    logic                    accept;
    logic [BAND_W:0]         first_band;
    logic [BAND_W:0]         nxt_band;
    logic [TAP_W-1:0]        newest;
    logic [30:0]             prod_sm;
    logic signed [ACC_W-1:0] acc_sum;
    logic [16:0]             res;

    // Lowest enabled band at or above 'from'; MSB of the result says whether one exists.
    function automatic logic [BAND_W:0] find_band(input logic [BANDS-1:0] mask, input int from);
        logic [BAND_W:0] r;
        r = '0;
        for (int i = BANDS - 1; i >= 0; i--) begin
            if (mask[i] && i >= from) begin
                r = {1'b1, BAND_W'(i)};
            end
        end
        return r;
    endfunction

    assign accept     = in_valid & (state_q == IDLE);
    assign first_band = find_band(band_en, 0);
    assign nxt_band   = find_band(mask_q, int'(band_q) + 1);
    assign newest     = (wr_ptr_q == '0) ? LAST_TAP : wr_ptr_q - TAP_W'(1);

    fir_sm_mult u_mult (
        .a_i (coef_data),
        .b_i (hist_q[samp_ptr_q]),
        .p_o (prod_sm)
    );

    assign acc_sum = acc_q + sm_to_tc(prod_sm);
    assign res     = tc_to_sm(acc_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && band_en != '0) state_d = MAC;
            MAC:     if (m_q == M_LAST) state_d = DONE;
            DONE:    state_d = nxt_band[BAND_W] ? MAC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Coefficient reads run one cycle ahead of the accumulate that consumes them.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        coef_rd   = 1'b0;
        coef_addr = '0;
        unique case (state_q)
            IDLE: in_ready = 1'b1;
            MAC: begin
                busy = 1'b1;
                if (m_q != M_LAST) begin
                    coef_rd   = 1'b1;
                    coef_addr = {band_q, m_q[TAP_W-1:0]};
                end
            end
            DONE:    busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q         <= '0;
            band_q      <= '0;
            mask_q      <= '0;
            wr_ptr_q    <= '0;
            samp_ptr_q  <= '0;
            acc_q       <= '0;
            fir_out_q   <= '0;
            out_valid_q <= 1'b0;
            out_band_q  <= '0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < ORDER; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        hist_q[wr_ptr_q] <= fir_in;
                        wr_ptr_q         <= (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + TAP_W'(1);
                        samp_ptr_q       <= wr_ptr_q;
                        mask_q           <= band_en;
                        band_q           <= first_band[BAND_W-1:0];
                        m_q              <= '0;
                        acc_q            <= '0;
                    end
                end
                MAC: begin
                    m_q <= m_q + (TAP_W+1)'(1);
                    if (m_q != '0) begin
                        acc_q      <= acc_sum;
                        samp_ptr_q <= (samp_ptr_q == '0) ? LAST_TAP : samp_ptr_q - TAP_W'(1);
                    end
                    // The final tap's sum is converted straight into the output register.
                    if (m_q == M_LAST) begin
                        fir_out_q   <= res[15:0];
                        out_valid_q <= 1'b1;
                        out_band_q  <= band_q;
                        if (res[16]) begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    band_q     <= nxt_band[BAND_W-1:0];
                    m_q        <= '0;
                    acc_q      <= '0;
                    samp_ptr_q <= newest;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_band  = out_band_q;
    assign fir_out   = fir_out_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/fir_band_scheduler.md
Name: fir_band_scheduler

Overview:
- Time-multiplexed FIR engine for the 4-band, 16-bit sign-magnitude filter bank. Replaces per-tap parallel multipliers with one shared sign-magnitude MAC.
- Sequences that MAC over each enabled band's coefficient set from an external coefficient ROM.
- Keeps one shared sample history (circular buffer).
- Emits one 16-bit result per enabled band per accepted input sample.

Parameters:
- ORDER, 30, taps per band (2..32).
- BANDS, 4, number of coefficient sets.
- TAP_W, 5, tap index width (ceil log2 ORDER).
- BAND_W, 2, band index width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fir_in valid.
- in_ready  out  1  block can accept a sample.
- fir_in  in  16  sample, sign-magnitude: bit15 sign, [14:0] Q0.15 magnitude.
- band_en  in  BANDS  band enable mask, sampled on accept.
- coef_addr  out  BAND_W+TAP_W  {band, tap} to coefficient ROM.
- coef_rd  out  1  ROM read strobe.
- coef_data  in  16  sign-magnitude coefficient, valid 1 cycle after coef_rd.
- out_valid  out  1  one-cycle result strobe.
- out_band  out  BAND_W  band of current result.
- fir_out  out  16  sign-magnitude result; holds between strobes.
- busy  out  1  not IDLE.
- overflow  out  1  sticky saturation flag.

Behaviour:
- Reset (async): state IDLE; history all zero; wr_ptr=0; acc=0; in_ready=1. All other outputs 0, including overflow.
- Accept = in_valid & in_ready; in_ready=1 only in IDLE.
- On the accept edge:
  - fir_in is written to hist[wr_ptr]; wr_ptr increments, wrapping ORDER-1 -> 0.
  - band_en is latched.
  - If the latched mask is 0: stay IDLE, produce no output.
  - Otherwise: go to MAC with band = lowest enabled, m=0, acc=0.
- Tap k uses sample hist[(newest_ptr - k) mod ORDER]; k=0 is the current sample.
- MAC state, m = 0..ORDER:
  - For m<ORDER: coef_rd=1, coef_addr={band,m}.
  - For m>=1: acc += prod(coef_data, sample tap m-1).
  - After m=ORDER: go to DONE.
- Product format:
  - sign = xor of operand signs; magnitude = 15x15 = 30 bits.
  - Converted to two's complement and accumulated in a 36-bit signed acc.
  - Sign-magnitude zero (either sign) contributes 0.
- DONE, one cycle:
  - out_valid=1, out_band=band.
  - fir_out = {sign(acc), |acc|[29:15]}, i.e. magnitude truncated toward zero.
  - If |acc| >= 2^30: magnitude = 0x7FFF and overflow is set.
  - A zero magnitude always yields 0x0000 (no negative zero).
  - Then go to MAC for the next higher enabled band with acc=0, or to IDLE if none remain.
- Timing, with the accept edge in cycle A:
  - n-th enabled band strobes at cycle A + n*(ORDER+2), n=1..popcount.
  - in_ready rises the cycle after the last strobe.
  - ORDER=30, all bands enabled: strobes at A+32, A+64, A+96, A+128; in_ready=1 at A+129.
- fir_in and band_en changes while busy are ignored.
- Reset mid-operation aborts immediately: no out_valid, history cleared.
- overflow clears only on reset.

Decomposition:
- Shared package fir_pkg holds:
  - ORDER, BANDS, TAP_W, BAND_W;
  - state enum {IDLE, MAC, DONE};
  - sign-magnitude <-> two's-complement conversion functions;
  - the saturation constant 0x7FFF.
- One sub-module: fir_sm_mult, a combinational 16x16 sign-magnitude multiply returning a 31-bit sign-magnitude product.
- The scheduler instantiates fir_sm_mult once.

Test Plan:
- Single tap: band_en=0001; ROM band0 tap0=0x4000, other taps 0; accept 0x2000 at A -> out_valid at A+32, out_band=0, fir_out=0x1000, in_ready=1 at A+33.
- Impulse: band1 loaded with delta set (tap14=0x17C0, tap11=0x8260); feed 0x7FFF then 29 zeros -> the (k+1)-th output equals coefficient k with magnitude-1 and the same sign. Includes 0x17BF at k=14 and 0x825F at k=11; zero taps give 0x0000. Continue 10 more zeros to check wr_ptr wrap, and all outputs return to 0x0000.
- Saturation: band2 taps all 0x7FFF; feed 30 samples of 0x7FFF -> 30th output 0x7FFF, overflow=1. Repeat with 0xFFFF samples -> 0xFFFF; overflow stays 1 until rst.
- Sparse mask: band_en=1010 -> strobes only at A+32 (band 1) and A+64 (band 3). in_ready=1 at A+65. band_en changed to 1111 mid-run is ignored.
- Empty mask: band_en=0000; accept 0x1234 -> in_ready=1 at A+1, no out_valid. Next sample with band_en=0001 and tap1=0x7FFF -> fir_out=0x1233.
- Reset mid-MAC: rst pulsed at A+10 -> no out_valid, busy=0 and in_ready=1 asynchronously. A following single-tap run sees zero history (tap1 contribution 0).
